// File: rtl/decoder_pkg.sv
// Shared types and widths for the sequenced 4-to-16 decoder.
package decoder_pkg;

    localparam int CODE_W = 4;
    localparam int OUT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/decoder3_8.sv
// Combinational 3-to-8 one-hot decoder with enable; all zero when disabled.
module decoder3_8 (
    input  logic       e,
    input  logic [2:0] w,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (e) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder4_16_seq.sv
// Sequenced 4-to-16 decoder: accepts a code, drives a one-hot strobe for hold+1
// cycles, then forces a one-cycle all-zero gap before the next strobe.
module decoder4_16_seq
    import decoder_pkg::*;
#(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    input  logic [HOLD_W-1:0] hold,
    output logic              code_ready,
    output logic [OUT_W-1:0]  y,
    output logic              busy,
    output logic              done
);

    state_t              state_p1, state_nxt;
    logic [HOLD_W-1:0]   cnt_p1, cnt_nxt;
    logic [CODE_W-1:0]   code_p1, code_sel;
    logic [OUT_W-1:0]    y_p1, y_nxt;
    logic                done_p1, done_nxt;
    logic                accept;
    logic                drv_nxt;

    assign code_ready = en && (state_p1 == IDLE || state_p1 == GAP);
    assign accept     = code_valid && code_ready;

    always_comb begin
        state_nxt = state_p1;
        cnt_nxt   = cnt_p1;
        case (state_p1)
            IDLE: begin
                if (accept) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = hold;
                end
            end
            DRIVE: begin
                if (cnt_p1 == '0 || !en) begin
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt_p1 - HOLD_W'(1);
                end
            end
            GAP: begin
                if (accept) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = hold;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decode the code the next cycle will drive, so y is registered yet aligned with DRIVE.
    assign code_sel = accept ? code : code_p1;
    assign drv_nxt  = (state_nxt == DRIVE);
    assign done_nxt = (state_p1 == DRIVE) && (cnt_p1 == '0) && en;

    decoder3_8 u_dec_lo (
        .e (drv_nxt && !code_sel[3]),
        .w (code_sel[2:0]),
        .y (y_nxt[7:0])
    );

    decoder3_8 u_dec_hi (
        .e (drv_nxt && code_sel[3]),
        .w (code_sel[2:0]),
        .y (y_nxt[15:8])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= IDLE;
            cnt_p1   <= '0;
            code_p1  <= '0;
            y_p1     <= '0;
            done_p1  <= 1'b0;
        end else begin
            state_p1 <= state_nxt;
            cnt_p1   <= cnt_nxt;
            y_p1     <= y_nxt;
            done_p1  <= done_nxt;
            if (accept) begin
                code_p1 <= code;
            end
        end
    end

    assign y    = y_p1;
    assign busy = (state_p1 != IDLE);
    assign done = done_p1;

endmodule

// File: tb/tb_decoder4_16_seq.sv
// Directed bench for decoder4_16_seq: reset, single strobe, streaming, max hold, abort, all codes.
module tb_decoder4_16_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        code_valid;
    logic [3:0]  code;
    logic [3:0]  hold;
    logic        code_ready;
    logic [15:0] y;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    decoder4_16_seq #(.HOLD_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .code_valid (code_valid),
        .code       (code),
        .hold       (hold),
        .code_ready (code_ready),
        .y          (y),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; code_valid = 1'b0; code = 4'd0; hold = 4'd0;
        #2;
        vectors++;
        if (y !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_init: y=%h busy=%b done=%b, expected y=0000 busy=0 done=0", y, busy, done);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        en = 1'b1; code_valid = 1'b1; code = 4'd9; hold = 4'd5;
        tick();
        code_valid = 1'b0;
        vectors++;
        if (y !== 16'h0200 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_strobe: y=%h busy=%b, expected y=0200 busy=1", y, busy);
        end
        tick(); tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (y !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: y=%h busy=%b done=%b, expected all 0", y, busy, done);
        end
        #1;
        rst_n = 1'b1;
        tick();
        vectors++;
        if (code_ready !== 1'b1 || y !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_release: code_ready=%b y=%h, expected code_ready=1 y=0000", code_ready, y);
        end
    endtask

    task automatic test_single();
        code_valid = 1'b1; code = 4'd5; hold = 4'd2;
        vectors++;
        if (code_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready: code_ready=%b, expected 1", code_ready);
        end
        tick();
        code_valid = 1'b0; code = 4'd11; hold = 4'd9;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (y !== 16'h0020 || code_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL single_drive[%0d]: y=%h ready=%b done=%b busy=%b, expected y=0020 ready=0 done=0 busy=1",
                         i, y, code_ready, done, busy);
            end
            tick();
        end
        vectors++;
        if (y !== 16'h0000 || done !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_gap: y=%h done=%b busy=%b, expected y=0000 done=1 busy=1", y, done, busy);
        end
        tick();
        vectors++;
        if (y !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: y=%h done=%b busy=%b, expected y=0000 done=0 busy=0", y, done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_y [6];
        logic        exp_d [6];
        logic [3:0]  next_code [6];
        exp_y = '{16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h0100, 16'h0000};
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        next_code = '{4'd15, 4'd15, 4'd8, 4'd8, 4'd8, 4'd8};
        hold = 4'd0; code = 4'd0; code_valid = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (y !== exp_y[i] || done !== exp_d[i]) begin
                miscompares++;
                $display("FAIL b2b[%0d]: y=%h done=%b, expected y=%h done=%b", i, y, done, exp_y[i], exp_d[i]);
            end
            code = next_code[i];
            if (i == 4) code_valid = 1'b0;
            tick();
        end
        vectors++;
        if (y !== 16'h0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: y=%h busy=%b, expected y=0000 busy=0", y, busy);
        end
    endtask

    task automatic test_max_hold();
        code_valid = 1'b1; code = 4'd3; hold = 4'd15;
        tick();
        code_valid = 1'b0; hold = 4'd0;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (y !== 16'h0008 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL maxhold_drive[%0d]: y=%h done=%b, expected y=0008 done=0", i, y, done);
            end
            tick();
        end
        vectors++;
        if (y !== 16'h0000 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL maxhold_gap: y=%h done=%b, expected y=0000 done=1", y, done);
        end
        tick();
        vectors++;
        if (y !== 16'h0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL maxhold_idle: y=%h busy=%b, expected y=0000 busy=0", y, busy);
        end
    endtask

    task automatic test_abort();
        code_valid = 1'b1; code = 4'd12; hold = 4'd7;
        tick();
        code_valid = 1'b0;
        tick(); tick();
        vectors++;
        if (y !== 16'h1000) begin
            miscompares++;
            $display("FAIL abort_drive3: y=%h, expected 1000", y);
        end
        en = 1'b0; code_valid = 1'b1; code = 4'd1; hold = 4'd1;
        #1;
        vectors++;
        if (code_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_ready: code_ready=%b, expected 0", code_ready);
        end
        tick();
        vectors++;
        if (y !== 16'h0000 || done !== 1'b0 || code_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_gap: y=%h done=%b ready=%b, expected y=0000 done=0 ready=0", y, done, code_ready);
        end
        tick();
        vectors++;
        if (y !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: y=%h busy=%b done=%b, expected all 0", y, busy, done);
        end
        tick();
        vectors++;
        if (y !== 16'h0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_accept: y=%h busy=%b, expected y=0000 busy=0", y, busy);
        end
        code_valid = 1'b0; en = 1'b1;
    endtask

    task automatic test_exhaustive();
        logic [15:0] exp;
        int h;
        for (int c = 0; c < 16; c++) begin
            h = c % 4;
            exp = 16'h0001 << c;
            code_valid = 1'b1; code = 4'(c); hold = 4'(h);
            tick();
            code = 4'(c) ^ 4'd5; hold = 4'd3;
            for (int k = 0; k <= h; k++) begin
                vectors++;
                if (!$onehot(y) || y !== exp || code_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL exh_drive c=%0d k=%0d: y=%h ready=%b, expected y=%h ready=0", c, k, y, code_ready, exp);
                end
                if (k == h) code_valid = 1'b0;
                tick();
            end
            vectors++;
            if (y !== 16'h0000 || done !== 1'b1) begin
                miscompares++;
                $display("FAIL exh_gap c=%0d: y=%h done=%b, expected y=0000 done=1", c, y, done);
            end
            tick();
            vectors++;
            if (y !== 16'h0000 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL exh_idle c=%0d: y=%h busy=%b, expected y=0000 busy=0", c, y, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_max_hold();
        test_abort();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder4_16_seq.md
# decoder4_16_seq

Sequenced 4-to-16 one-hot decoder with a valid/ready input handshake, a programmable output hold time, and a guaranteed all-zero gap between consecutive codes. It is the decode-side counterpart of the team's priority encoders: a 4-bit code becomes a timed one-hot strobe on 16 select lines, for example for row/segment select or demux enables. It is built hierarchically from two 3-to-8 decoders, in the same style as the encoder tree.

## Interface
- `HOLD_W`, default 4: width of the hold-count input and of the internal hold counter.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: block enable. Low means no new accepts, and an active strobe is aborted.
- `code_valid` input, 1 bit: upstream presents a code.
- `code` input, 4 bits: index of the output line to strobe.
- `hold` input, `HOLD_W` bits: strobe length minus 1. Sampled at accept.
- `code_ready` output, 1 bit: block can accept a code this cycle.
- `y` output, 16 bits: registered one-hot output, or all zero.
- `busy` output, 1 bit: high in DRIVE or GAP.
- `done` output, 1 bit: one-cycle pulse when a strobe completes normally.

## Operation
- Reset values: state IDLE, `y`=0, `busy`=0, `done`=0, hold counter 0, code register 0.
- `code_ready` = `en` && (state==IDLE || state==GAP). It is combinational from state and `en`.
- Accept happens on a cycle with `code_valid` && `code_ready`. On accept:
  - latch `code` and `hold`;
  - counter := `hold`;
  - next state DRIVE.
- IDLE: `y`=0. Accept goes to DRIVE; otherwise stay in IDLE.
- DRIVE: `y` = one-hot of the latched code, so bit `code` = 1 and all other bits 0.
  - If counter==0 or `en`==0: go to GAP.
  - Otherwise decrement the counter.
- GAP: `y`=0 for exactly one cycle.
  - `done`=1 in the GAP cycle only if DRIVE ended with counter==0 and `en`==1.
  - An abort (`en` low) gives `done`=0.
  - Accept in GAP goes to DRIVE; otherwise go to IDLE.
- `en` low in IDLE or GAP: no accept, and the block goes or stays in IDLE.
- Decode: `code[3]` selects which 3-to-8 sub-decoder is enabled. The low sub-decoder drives `y[7:0]` and the high one drives `y[15:8]`. `code[2:0]` drives both. At most one bit of `y` is ever set.
- `code_valid` while not ready: ignored. Upstream holds the code.

## Timing
- Accept at edge T gives `y` valid from T+1 for exactly `hold`+1 cycles.
- GAP starts at T+2+`hold`. `done` is high in that same cycle.
- Back-to-back streaming: period is `hold`+2 cycles, with a guaranteed 1-cycle zero between strobes (break-before-make).
- `hold`=0 gives a 1-cycle strobe, and the block can accept again 2 cycles after the previous accept.
- `hold`=2^HOLD_W−1 gives 2^HOLD_W strobe cycles. The counter never wraps.
- Abort: `en` low during any DRIVE cycle gives `y`=0 on the next cycle (GAP, no `done`). Total abort latency is 1 cycle.
- `rst_n` low at any time: `y`, `busy`, `done` are 0 immediately (asynchronous). The first accept is possible in the first cycle after release.
- Changing `hold` or `code` after accept has no effect on the current strobe.

## Structure
- Shared package `decoder_pkg`:
  - state enum {IDLE, DRIVE, GAP};
  - localparam `CODE_W`=4 and `OUT_W`=16.
- Sub-module `decoder3_8`: combinational, inputs `e` and `w[2:0]`, output `y[7:0]` (one-hot when `e`=1, otherwise 0). It is instantiated twice.
- Top level contains the FSM, the hold counter, the code/hold registers, and the `y` output register.

## Test plan
- Reset during a DRIVE strobe (`code`=9, `hold`=5), assert `rst_n`=0 mid-strobe:
  - `y`=0, `busy`=0, `done`=0 asynchronously;
  - after release, `code_ready`=1.
- Single accept of `code`=5, `hold`=2, `en`=1:
  - `y`=16'h0020 for 3 cycles;
  - then `y`=0 with `done`=1 for 1 cycle;
  - `code_ready` is 0 during DRIVE.
- Back-to-back with `code_valid` held, codes 0, 15, 8, `hold`=0:
  - `y` sequence 0001, 0000, 8000, 0000, 0100, 0000;
  - `done` high in each zero cycle.
- Maximum hold, `hold`=15, `code`=3: `y`=16'h0008 for 16 cycles, no wrap, then GAP.
- Abort: `code`=12, `hold`=7, drop `en` in the third DRIVE cycle:
  - `y`=0 next cycle;
  - `done`=0;
  - no accept while `en`=0;
  - return to IDLE.
- Exhaustive: all 16 codes accepted. Check `$onehot(y)` in DRIVE, `y`==0 outside DRIVE, and that `code_valid` is ignored while `code_ready`=0.
